// File: rtl/cnt_mon_pkg.sv
// Shared definitions for the count sequence monitor: FSM encoding and the
// error counter width and saturation value.
package cnt_mon_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    STALLED = 2'd2
  } mon_state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/count_sequence_monitor_if.sv
// Bus between the monitored count source / status consumers and the monitor.
// The slave modport is the monitor's view.
interface count_sequence_monitor_if
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int PERIOD_W = 24
);

  logic [WIDTH-1:0]     count_in;
  logic                 clear_err;
  logic [WIDTH-1:0]     value;
  logic                 step_valid;
  logic                 step_ok;
  logic                 wrap;
  logic [PERIOD_W-1:0]  period;
  logic                 stall;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output count_in, clear_err,
    input  value, step_valid, step_ok, wrap, period, stall, err_sticky, err_count
  );

  modport slave (
    input  count_in, clear_err,
    output value, step_valid, step_ok, wrap, period, stall, err_sticky, err_count
  );

endinterface

// File: rtl/bus_stable_sync.sv
// Multi-flop synchroniser plus stability filter for a slow asynchronous bus.
// stable_o is high while the synced bus has held cand_o for STABLE_CYCLES samples.
module bus_stable_sync #(
  parameter int WIDTH         = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] cand_o,
  output logic             stable_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SYNC_STAGES*WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0]       vld_q;
  logic [WIDTH-1:0]             synced;
  logic [WIDTH-1:0]             cand_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;

  assign synced = sync_q[SYNC_STAGES*WIDTH-1 -: WIDTH];

  // vld_q tracks chain fill after reset so the reset zeros are never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q  <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[(SYNC_STAGES-1)*WIDTH-1:0], bus_i};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      cand_q <= synced;
      cnt_q  <= cnt_d;
    end
  end

  // cnt_d is the run length of equal samples including the current one.
  always_comb begin
    cnt_d = cnt_q;
    if (!vld_q[SYNC_STAGES-1]) begin
      cnt_d = '0;
    end else if (synced != cand_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cand_o   = synced;
  assign stable_o = (cnt_d == CNT_MAX);

endmodule

// File: rtl/count_sequence_monitor.sv
// Checks that a slow-domain count bus advances by +1 mod 2^WIDTH, measures the
// step period and flags stalls and bad steps.
module count_sequence_monitor
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 8000000,
  parameter int PERIOD_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  count_sequence_monitor_if.slave mon
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_P = PERIOD_W'(TIMEOUT);
  localparam logic [WIDTH-1:0]    ALL_ONES  = '1;

  mon_state_e           state_q, state_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 step_valid_q, step_valid_d;
  logic                 step_ok_q, step_ok_d;
  logic                 wrap_q, wrap_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PERIOD_W-1:0]  timer_q, timer_d;
  logic                 stall_q, stall_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]    cand;
  logic                stable;
  logic                accept;
  logic                bad_step;
  logic [WIDTH-1:0]    value_inc;
  logic [PERIOD_W-1:0] timer_inc;

  bus_stable_sync #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus_i   (mon.count_in),
    .cand_o  (cand),
    .stable_o(stable)
  );

  assign value_inc = value_q + WIDTH'(1);
  assign timer_inc = (timer_q == TIMEOUT_P) ? timer_q : timer_q + PERIOD_W'(1);
  assign accept    = stable && ((state_q == ACQUIRE) || (cand != value_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACQUIRE;
      value_q      <= '0;
      step_valid_q <= 1'b0;
      step_ok_q    <= 1'b0;
      wrap_q       <= 1'b0;
      period_q     <= '0;
      timer_q      <= '0;
      stall_q      <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      step_valid_q <= step_valid_d;
      step_ok_q    <= step_ok_d;
      wrap_q       <= wrap_d;
      period_q     <= period_d;
      timer_q      <= timer_d;
      stall_q      <= stall_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    step_valid_d = 1'b0;
    step_ok_d    = 1'b0;
    wrap_d       = 1'b0;
    period_d     = period_q;
    timer_d      = timer_q;
    stall_d      = stall_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    bad_step     = 1'b0;

    case (state_q)
      ACQUIRE: begin
        if (accept) begin
          timer_d = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (accept) begin
          period_d = timer_q + PERIOD_W'(1);
          timer_d  = '0;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_P) begin
            stall_d = 1'b1;
            state_d = STALLED;
          end
        end
      end
      STALLED: begin
        // The gap ran past TIMEOUT, so the measured period is meaningless.
        if (accept) begin
          period_d = '0;
          timer_d  = '0;
          stall_d  = 1'b0;
          state_d  = TRACK;
        end
      end
      default: state_d = ACQUIRE;
    endcase

    if (accept) begin
      value_d = cand;
      if (state_q != ACQUIRE) begin
        step_valid_d = 1'b1;
        step_ok_d    = (cand == value_inc);
        wrap_d       = (value_q == ALL_ONES) && (cand == '0);
        bad_step     = (cand != value_inc);
      end
    end

    // A clear coincident with a bad step wins.
    if (mon.clear_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (bad_step) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != ERR_CNT_MAX) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign mon.value      = value_q;
  assign mon.step_valid = step_valid_q;
  assign mon.step_ok    = step_ok_q;
  assign mon.wrap       = wrap_q;
  assign mon.period     = period_q;
  assign mon.stall      = stall_q;
  assign mon.err_sticky = err_sticky_q;
  assign mon.err_count  = err_cnt_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Directed and randomised bench for count_sequence_monitor against a
// window-based reference model of acceptance, step checking and timing.
module tb_count_sequence_monitor;

  localparam int W   = 3;
  localparam int S   = 2;
  localparam int STB = 4;
  localparam int TO  = 100;
  localparam int PW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  count_sequence_monitor_if #(.WIDTH(W), .PERIOD_W(PW)) mon_if ();

  count_sequence_monitor #(
    .WIDTH        (W),
    .SYNC_STAGES  (S),
    .STABLE_CYCLES(STB),
    .TIMEOUT      (TO),
    .PERIOD_W     (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (mon_if)
  );

  int hist[$];
  bit m_acq, m_sticky, e_sv, e_ok, e_wrap, e_stall;
  int m_value, m_last, m_err, e_period;
  int n_cmp = 0;
  int n_mis = 0;
  int sv_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Accepted value = STB equal input samples ending S edges ago.
  task automatic model_edge();
    int nn, cand, gap;
    bit win, bad;
    if (!rst_n) begin
      hist.delete();
      m_acq = 0; m_value = 0; m_last = 0; m_err = 0; m_sticky = 0;
      e_sv = 0; e_ok = 0; e_wrap = 0; e_period = 0; e_stall = 0;
      return;
    end
    hist.push_back(int'(mon_if.count_in));
    nn = hist.size();
    e_sv = 0; e_ok = 0; e_wrap = 0; bad = 0; cand = 0;
    win = (nn >= S + STB);
    if (win) begin
      cand = hist[nn-S-1];
      for (int i = nn - S - STB; i < nn - S; i++)
        if (hist[i] != cand) win = 0;
    end
    if (win && (!m_acq || cand != m_value)) begin
      if (!m_acq) begin
        m_acq = 1;
      end else begin
        gap      = nn - m_last;
        e_sv     = 1;
        e_ok     = (cand == (m_value + 1) % (1 << W));
        e_wrap   = (m_value == (1 << W) - 1) && (cand == 0);
        e_period = (gap <= TO) ? gap : 0;
        bad      = !e_ok;
      end
      m_value = cand;
      m_last  = nn;
    end
    e_stall = m_acq && ((nn - m_last) >= TO);
    if (mon_if.clear_err) begin
      m_err = 0; m_sticky = 0;
    end else if (bad) begin
      m_sticky = 1;
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic check_all();
    chk("value",      mon_if.value,      m_value);
    chk("step_valid", mon_if.step_valid, e_sv);
    chk("step_ok",    mon_if.step_ok,    e_ok);
    chk("wrap",       mon_if.wrap,       e_wrap);
    chk("period",     mon_if.period,     e_period);
    chk("stall",      mon_if.stall,      e_stall);
    chk("err_sticky", mon_if.err_sticky, m_sticky);
    chk("err_count",  mon_if.err_count,  m_err);
    if (mon_if.step_valid === 1'b1) begin
      sv_seen++;
      $display("step t=%0t value=%0d ok=%0b wrap=%0b period=%0d errs=%0d",
               $time, mon_if.value, mon_if.step_ok, mon_if.wrap, mon_if.period, mon_if.err_count);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input int v, input int k);
    mon_if.count_in = W'(v);
    repeat (k) cycle();
  endtask

  initial begin
    int v, len, base;
    mon_if.count_in  = '0;
    mon_if.clear_err = 1'b0;

    // Reset, then acquire 5 without a step pulse.
    mon_if.count_in = 3'd5;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (5) cycle();
    chk("acq_not_yet", mon_if.value, 0);
    cycle();
    chk("acq_value", mon_if.value, 5);
    chk("acq_no_step", sv_seen, 0);
    repeat (14) cycle();

    // Good steps with wrap, 20-cycle period.
    base = sv_seen;
    hold(6, 20); hold(7, 20); hold(0, 20);
    chk("good_steps", sv_seen - base, 3);
    chk("period_20", mon_if.period, 20);
    chk("no_err", mon_if.err_count, 0);

    // Jump 2 -> 4, then clear.
    hold(1, 20); hold(2, 20); hold(4, 20);
    chk("jump_sticky", mon_if.err_sticky, 1);
    chk("jump_count", mon_if.err_count, 1);
    mon_if.clear_err = 1'b1; cycle(); mon_if.clear_err = 1'b0; cycle();
    chk("clear_sticky", mon_if.err_sticky, 0);
    chk("clear_count", mon_if.err_count, 0);

    // Short glitch, then stall, then recovery.
    hold(5, 20);
    base = sv_seen;
    hold(2, 2); hold(5, 120);
    chk("glitch_no_step", sv_seen - base, 0);
    chk("glitch_no_err", mon_if.err_count, 0);
    chk("stall_set", mon_if.stall, 1);
    hold(6, 20);
    chk("stall_clr", mon_if.stall, 0);
    chk("stall_period", mon_if.period, 0);

    // Saturate the error counter, then clear on the same edge as a bad step.
    v = 6;
    repeat (300) begin
      v = (v + 2) % 8;
      hold(v, 6);
    end
    chk("err_sat", mon_if.err_count, 255);
    v = (v + 2) % 8;
    mon_if.count_in = W'(v);
    repeat (5) cycle();
    mon_if.clear_err = 1'b1; cycle(); mon_if.clear_err = 1'b0;
    chk("clr_coinc_step", mon_if.step_valid, 1);
    chk("clr_coinc_count", mon_if.err_count, 0);
    chk("clr_coinc_sticky", mon_if.err_sticky, 0);
    repeat (10) cycle();

    // Random mix of good steps, jumps, glitches, stalls and clears.
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 7));
      else v = (v + 1) % 8;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 130))
                                        : int'($urandom_range(1, 25));
      mon_if.count_in  = W'(v);
      mon_if.clear_err = ($urandom_range(0, 9) == 0);
      cycle();
      mon_if.clear_err = 1'b0;
      repeat (len - 1) cycle();
    end

    // Reset in the middle of tracking; first value after reset is not checked.
    hold(6, 20);
    rst_n = 1'b0;
    repeat (3) cycle();
    mon_if.count_in = 3'd1;
    rst_n = 1'b1;
    repeat (20) cycle();
    chk("rst_value", mon_if.value, 1);
    chk("rst_sticky", mon_if.err_sticky, 0);
    chk("rst_count", mon_if.err_count, 0);
    hold(2, 20);
    chk("rst_next_ok", mon_if.err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
